// File: rtl/mines_pkg.sv
// Shared definitions for the minesweeper player front end: board size,
// cell index width and the move issuer state encoding.
package mines_pkg;

  localparam int BOARD_ROWS = 5;
  localparam int BOARD_COLS = 5;
  localparam int IDX_W      = 5;
  localparam int CELLS      = BOARD_ROWS * BOARD_COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    LOCK  = 2'd3
  } state_t;

  // Linear cell index, row-major.
  function automatic logic [IDX_W-1:0] cell_index(input logic [2:0] row,
                                                  input logic [2:0] col,
                                                  input int cols);
    int idx;
    idx = int'(row) * cols + int'(col);
    return idx[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one level button: a held button yields a single
// one-cycle event.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= btn;
  end

  assign evt = btn & ~prev;

endmodule

// File: rtl/move_issuer.sv
// Cursor-to-move front end for the minesweeper core: one move in flight at a
// time. Optional MOVE_ISSUER_SKIP_CLEARED_EN ignores selects on cleared cells.
module move_issuer
  import mines_pkg::*;
#(
  parameter int ROWS     = BOARD_ROWS,
  parameter int COLS     = BOARD_COLS,
  parameter int WAIT_MAX = 64
) (
  input  logic              in_clka,
  input  logic              in_restart,
  input  logic              in_up,
  input  logic              in_down,
  input  logic              in_left,
  input  logic              in_right,
  input  logic              in_select,
  input  logic              in_display_done,
  input  logic              in_gameover,
  input  logic              in_win,
  input  logic [CELLS-1:0]  in_cleared,
  output logic [IDX_W-1:0]  out_data,
  output logic              out_data_in,
  output logic [2:0]        out_row,
  output logic [2:0]        out_col,
  output logic              out_busy,
  output logic [7:0]        out_moves,
  output logic              out_timeout,
  output logic              out_locked
);

  localparam int          CNT_W     = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
  localparam logic [2:0]  LAST_ROW  = 3'(ROWS - 1);
  localparam logic [2:0]  LAST_COL  = 3'(COLS - 1);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              up_evt, down_evt, left_evt, right_evt, sel_evt;
  logic              sel_ok, lock_req, cursor_en;
  logic [2:0]        row_nxt, col_nxt;
  logic [IDX_W-1:0]  cur_idx;

  btn_edge u_up    (.clk(in_clka), .rst(in_restart), .btn(in_up),     .evt(up_evt));
  btn_edge u_down  (.clk(in_clka), .rst(in_restart), .btn(in_down),   .evt(down_evt));
  btn_edge u_left  (.clk(in_clka), .rst(in_restart), .btn(in_left),   .evt(left_evt));
  btn_edge u_right (.clk(in_clka), .rst(in_restart), .btn(in_right),  .evt(right_evt));
  btn_edge u_sel   (.clk(in_clka), .rst(in_restart), .btn(in_select), .evt(sel_evt));

  assign cur_idx  = cell_index(out_row, out_col, COLS);
  assign lock_req = in_gameover | in_win;

`ifdef MOVE_ISSUER_SKIP_CLEARED_EN
  assign sel_ok = sel_evt & ~in_cleared[cur_idx];
`else
  logic cleared_unused;
  assign cleared_unused = ^in_cleared;
  assign sel_ok = sel_evt;
`endif

  // An accepted select in IDLE freezes the cursor so out_data is the pre-move cell.
  assign cursor_en = ~lock_req & (((state == IDLE) & ~sel_ok) | (state == WAIT));

  always_comb begin
    row_nxt = out_row;
    col_nxt = out_col;
    if (cursor_en) begin
      if (up_evt)         row_nxt = (out_row == 3'd0) ? LAST_ROW : out_row - 3'd1;
      else if (down_evt)  row_nxt = (out_row == LAST_ROW) ? 3'd0 : out_row + 3'd1;
      else if (left_evt)  col_nxt = (out_col == 3'd0) ? LAST_COL : out_col - 3'd1;
      else if (right_evt) col_nxt = (out_col == LAST_COL) ? 3'd0 : out_col + 3'd1;
    end
  end

  assign out_busy = (state == ISSUE) | (state == WAIT);

  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      out_row     <= 3'd0;
      out_col     <= 3'd0;
      out_data    <= '0;
      out_data_in <= 1'b0;
      out_moves   <= 8'd0;
      out_timeout <= 1'b0;
      out_locked  <= 1'b0;
    end else begin
      out_row     <= row_nxt;
      out_col     <= col_nxt;
      out_data_in <= 1'b0;
      if (lock_req) begin
        state      <= LOCK;
        out_locked <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (sel_ok) begin
              out_data    <= cur_idx;
              out_data_in <= 1'b1;
              if (out_moves != 8'hFF) out_moves <= out_moves + 8'd1;
              state       <= ISSUE;
            end
          end
          ISSUE: begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
          WAIT: begin
            // Done wins over a timeout landing in the same cycle.
            if (in_display_done) begin
              state <= IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
              out_timeout <= 1'b1;
              state       <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          default: begin
            state      <= LOCK;
            out_locked <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
